dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder at the far end of the MEM-stage interface. It accepts one load/store request at a time carrying address, store data, access width, sign-extend flag and write flag, and performs the access against an internal word-organised RAM after a fixed latency. Stores merge into the addressed byte lanes; loads return an extracted, sign- or zero-extended value. The core stalls the MEM stage until `resp_valid_o` is asserted.

## Interface
- `DEPTH_WORDS`, 256: RAM size in 32-bit words; power of two.
- `LATENCY`, 2: cycles from request acceptance to response; must be 1 or more.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  responder can accept a request.
- `addr_i`  in  32  byte address (ALU result).
- `wdata_i`  in  32  store data (rs2 value); the low bytes are used for sub-word stores.
- `width_i`  in  2  access width: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- `sign_extend_i`  in  1  load sign-extends when 1, zero-extends when 0.
- `write_i`  in  1  1 = store, 0 = load.
- `resp_valid_o`  out  1  one-cycle response pulse.
- `rdata_o`  out  32  load result; 0 for stores and errors.
- `misalign_o`  out  1  error flag, qualified by `resp_valid_o`.

## Operation
- **States:** IDLE, BUSY, RESP.
- **Request latching:** all request fields are latched at acceptance, i.e. when `req_valid_i` and `req_ready_o` are both high. Inputs are ignored while in BUSY.
- **Error detection at acceptance:** a request is an error when any of these holds:
  - half access with `addr_i[0]` = 1;
  - word access with `addr_i[1:0]` ≠ 0;
  - `width_i` = 11.
- **Error handling:** an error request goes directly to RESP after 1 cycle, regardless of `LATENCY`. The response has `misalign_o` = 1 and `rdata_o` = 0. No RAM access occurs; a store is dropped.
- **Normal handling:** a valid request enters BUSY with a counter loaded to `LATENCY`-1. The counter decrements each cycle. The state moves to RESP on the edge where the counter is 0.
- **Word index:** `addr_i[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo the RAM size.
- **Store:** byte-enables come from width and `addr_i[1:0]`:
  - byte: lane = `addr[1:0]`, data = `wdata_i[7:0]`;
  - half: lanes `addr[1]*2` and `addr[1]*2+1`, data = `wdata_i[15:0]`;
  - word: all four lanes.
  
  Unselected bytes keep their old value. The write commits on the edge entering RESP. `rdata_o` = 0.
- **Load:** the addressed word is read. The selected byte or half is shifted to bit 0 and extended to 32 bits per `sign_extend_i`; a word load passes through unchanged. The result is registered into `rdata_o` on the edge entering RESP.
- **RESP:** lasts exactly one cycle, then the state returns to IDLE. `rdata_o` and `misalign_o` hold their values until the next response.
- **Handshake:** `req_ready_o` = 1 in IDLE and in RESP, 0 in BUSY. A request accepted in the RESP cycle starts immediately, giving back-to-back operation.
- **RAM:** contents are not reset; simulation initialises them to 0.

## Timing
- **Reset** (`rst_n` = 0 at a rising edge): state = IDLE, `req_ready_o` = 1, `resp_valid_o` = 0, `rdata_o` = 0, `misalign_o` = 0, counter = 0.
- **Reset mid-operation:** the request in flight is discarded and no response is produced. A store not yet committed is not written.
- **Normal latency:** for a request accepted at edge T, `resp_valid_o` is high during the cycle following edge T+`LATENCY`-1, i.e. `LATENCY` edges after acceptance.
  - `LATENCY` = 1 skips BUSY entirely.
- **Error latency:** always 1 edge after acceptance.
- **Read-after-write:** a load accepted in the RESP cycle of a store to the same word returns the newly written data. There is no bypass hazard, because the commit precedes the read.
- **Throughput:** one request per `LATENCY` cycles.
- **Ignored requests:** `req_valid_i` with `req_ready_o` = 0 is ignored; the requester holds its request until accepted.

## Test plan
1. **Reset:** hold `rst_n` = 0 for 2 cycles, release -> `req_ready_o` = 1, `resp_valid_o` = 0, `rdata_o` = 0, `misalign_o` = 0.
2. **Word store/load:**
   - store word 0xDEADBEEF @0x10 -> `resp_valid_o` exactly 2 cycles after acceptance, `rdata_o` = 0;
   - then load word @0x10 -> `rdata_o` = 0xDEADBEEF, `misalign_o` = 0.
3. **Byte/half merge and extension:** with 0xDEADBEEF @0x10, store byte 0x80 @0x11 -> word becomes 0xDEAD80EF. Then:
   - signed byte load @0x11 -> 0xFFFFFF80;
   - unsigned byte load @0x11 -> 0x00000080;
   - signed half load @0x12 -> 0xFFFFDEAD.
4. **Misalignment:**
   - half store @0x13 -> response after 1 cycle, `misalign_o` = 1, `rdata_o` = 0;
   - subsequent word load @0x10 -> 0xDEAD80EF (unchanged);
   - `width_i` = 11 -> `misalign_o` = 1.
5. **Back-to-back and wrap:**
   - store word 0x12345678 @0x0;
   - while the store is in RESP, present a load @(`DEPTH_WORDS`*4) -> accepted in the same cycle, returns 0x12345678;
   - `req_ready_o` stays 0 throughout BUSY.
6. **Reset mid-BUSY:** store 0xAAAAAAAA @0x20 into a word holding 0, assert `rst_n` = 0 one cycle after acceptance -> no `resp_valid_o`; a later load @0x20 returns 0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store against an internal word RAM.
// A good request is answered LATENCY cycles after acceptance and a bad one after a single cycle.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  width_i,
  input  logic        sign_extend_i,
  input  logic        write_i,
  output logic        resp_valid_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic [IDX_W+1:0] addr_p0;
  logic [31:0]      wdata_p0;
  logic [1:0]       width_p0;
  logic             sext_p0, write_p0;

  logic [31:0] mem [DEPTH_WORDS];

  logic             accept, req_err, access, err_resp;
  logic [IDX_W+1:0] op_addr;
  logic [31:0]      op_wdata, op_lanes, old_word, merged, load_val;
  logic [1:0]       op_width;
  logic             op_sext, op_write;
  logic [IDX_W-1:0] op_idx;
  logic [3:0]       op_be;
  logic             unused_addr;

  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lsb);
    case (width)
      2'b00:   return 1'b0;
      2'b01:   return lsb[0];
      2'b10:   return |lsb;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] width, input logic [1:0] lsb);
    case (width)
      2'b00:   return 4'b0001 << lsb;
      2'b01:   return lsb[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] width,
                                               input logic [1:0] lsb, input logic sext);
    logic [31:0]        shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    shifted = word >> {lsb, 3'b000};
    b = shifted[7:0];
    h = shifted[15:0];
    case (width)
      2'b00:   return sext ? 32'(b) : {24'h0, shifted[7:0]};
      2'b01:   return sext ? 32'(h) : {16'h0, shifted[15:0]};
      default: return word;
    endcase
  endfunction

  assign accept       = req_valid_i && req_ready_o;
  assign req_err      = is_misaligned(width_i, addr_i[1:0]);
  assign req_ready_o  = (state != BUSY);
  assign resp_valid_o = (state == RESP);
  assign unused_addr  = ^addr_i[31:IDX_W+2];

  // With LATENCY = 1 the access happens on the acceptance edge, so the live inputs are used
  assign op_addr  = (state == BUSY) ? addr_p0  : addr_i[IDX_W+1:0];
  assign op_wdata = (state == BUSY) ? wdata_p0 : wdata_i;
  assign op_width = (state == BUSY) ? width_p0 : width_i;
  assign op_sext  = (state == BUSY) ? sext_p0  : sign_extend_i;
  assign op_write = (state == BUSY) ? write_p0 : write_i;

  assign op_idx   = op_addr[IDX_W+1:2];
  assign old_word = mem[op_idx];
  assign op_be    = byte_enables(op_width, op_addr[1:0]);
  assign load_val = load_extract(old_word, op_width, op_addr[1:0], op_sext);

  always_comb begin
    case (op_width)
      2'b00:   op_lanes = {4{op_wdata[7:0]}};
      2'b01:   op_lanes = {2{op_wdata[15:0]}};
      default: op_lanes = op_wdata;
    endcase
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = op_be[i] ? op_lanes[8*i +: 8] : old_word[8*i +: 8];
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    access     = 1'b0;
    err_resp   = 1'b0;
    case (state)
      BUSY: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_next = RESP;
          access     = 1'b1;
        end
      end
      default: begin
        // IDLE and RESP both accept; RESP falls back to IDLE when nothing arrives
        state_next = IDLE;
        if (accept) begin
          if (req_err) begin
            state_next = RESP;
            err_resp   = 1'b1;
          end else if (LATENCY == 1) begin
            state_next = RESP;
            access     = 1'b1;
          end else begin
            state_next = BUSY;
            cnt_next   = CNT_LOAD;
          end
        end
      end
    endcase
  end

  // Control and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rdata_o    <= '0;
      misalign_o <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (err_resp) begin
        rdata_o    <= '0;
        misalign_o <= 1'b1;
      end else if (access) begin
        rdata_o    <= op_write ? 32'h0 : load_val;
        misalign_o <= 1'b0;
      end
    end
  end

  // Request capture (data only)
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= addr_i[IDX_W+1:0];
      wdata_p0 <= wdata_i;
      width_p0 <= width_i;
      sext_p0  <= sign_extend_i;
      write_p0 <= write_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && access && op_write)
      mem[op_idx] <= merged;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: constant vector table, hand-written multi-cycle sequences,
// and random traffic checked against a byte-addressed reference memory.
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, sign_extend = 1'b0, write = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [1:0]  width = '0;
  logic        req_ready, resp_valid, misalign;
  logic [31:0] rdata;

  int n_checks = 0, n_fail = 0;
  logic [7:0] ref_bytes [DEPTH*4];

  typedef struct {
    logic        wr;
    logic [1:0]  w;
    logic        sx;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .addr_i(addr), .wdata_i(wdata), .width_i(width), .sign_extend_i(sign_extend),
    .write_i(write), .resp_valid_o(resp_valid), .rdata_o(rdata), .misalign_o(misalign)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference: memory as a flat byte array indexed by address modulo its size
  task automatic model(input logic wr, input logic [1:0] w, input logic sx, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic mis);
    int base, n;
    longint v;
    base = int'(a % (DEPTH*4));
    mis  = (w == 2'd3) || (w == 2'd1 && a % 2 != 0) || (w == 2'd2 && a % 4 != 0);
    rd   = '0;
    if (!mis) begin
      n = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
      if (wr) begin
        for (int i = 0; i < n; i++) ref_bytes[base+i] = d[8*i +: 8];
      end else begin
        v = 0;
        for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(ref_bytes[base+i]);
        if (sx && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
        rd = v[31:0];
      end
    end
  endtask

  // Called #1 after a rising edge; returns cycles from acceptance to the response
  task automatic do_req(input logic wr, input logic [1:0] w, input logic sx, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic mis,
                        output int lat);
    int guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    req_valid = 1'b1; write = wr; width = w; sign_extend = sx; addr = a; wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; addr = $urandom(); wdata = $urandom(); width = 2'($urandom());
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = rdata;
    mis = misalign;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, mrd;
    logic        mis, mmis;
    int          lat, resp_cnt;

    for (int i = 0; i < DEPTH*4; i++) ref_bytes[i] = 8'h00;

    // Reset held for two edges
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset ready", {31'b0, req_ready}, 32'd1);
    check("reset resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset rdata", rdata, 32'h0);
    check("reset misalign", {31'b0, misalign}, 32'd0);

    // Known contents for the low 64 bytes
    for (int i = 0; i < 16; i++) begin
      do_req(1'b1, 2'd2, 1'b0, 32'(4*i), 32'h0, rd, mis, lat);
      model(1'b1, 2'd2, 1'b0, 32'(4*i), 32'h0, mrd, mmis);
    end

    // Back-to-back store then aliased load, ready low in BUSY
    req_valid = 1'b1; write = 1'b1; width = 2'd2; sign_extend = 1'b0; addr = 32'h0; wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b store busy ready", {31'b0, req_ready}, 32'd0);
    check("b2b store busy resp_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    check("b2b store resp_valid", {31'b0, resp_valid}, 32'd1);
    check("b2b store resp ready", {31'b0, req_ready}, 32'd1);
    check("b2b store rdata", rdata, 32'h0);
    model(1'b1, 2'd2, 1'b0, 32'h0, 32'h12345678, mrd, mmis);
    req_valid = 1'b1; write = 1'b0; width = 2'd2; addr = 32'(DEPTH*4);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b load accepted busy ready", {31'b0, req_ready}, 32'd0);
    check("b2b load busy resp_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    check("b2b load resp_valid", {31'b0, resp_valid}, 32'd1);
    check("b2b load rdata", rdata, 32'h12345678);

    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h11, 32'h12345680, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'h00000080, 1'b0});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h0000DEAD, 1'b0});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h13, 32'h0000FFFF, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h16, 32'hAAAA8001, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h16, 32'h0, 32'hFFFF8001, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h17, 32'h0, 32'hFFFFFF80, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h16, 32'h0, 32'h00000001, 1'b0});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'h80010000, 1'b0});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'hFFFFF004, 32'h0BADF00D, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 32'h0BADF00D, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h403, 32'h0, 32'h00000012, 1'b0});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h0, 32'h000000FF, 32'h0, 1'b0});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h0, 32'h0, 32'h000056FF, 1'b0});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 32'h00001234, 1'b0});

    foreach (tbl[i]) begin
      do_req(tbl[i].wr, tbl[i].w, tbl[i].sx, tbl[i].a, tbl[i].d, rd, mis, lat);
      model(tbl[i].wr, tbl[i].w, tbl[i].sx, tbl[i].a, tbl[i].d, mrd, mmis);
      check($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d misalign", i), {31'b0, mis}, {31'b0, tbl[i].exp_mis});
      check($sformatf("vec%0d latency", i), 32'(lat), tbl[i].exp_mis ? 32'd1 : 32'(LAT));
    end

    // Reset one cycle into BUSY discards the store
    req_valid = 1'b1; write = 1'b1; width = 2'd2; addr = 32'h20; wdata = 32'hAAAAAAAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midreset ready", {31'b0, req_ready}, 32'd1);
    resp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) resp_cnt++;
      @(posedge clk); #1;
    end
    check("midreset no response", 32'(resp_cnt), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, mis, lat);
    check("midreset load rdata", rd, 32'h0);
    check("midreset load latency", 32'(lat), 32'(LAT));

    // Random traffic over the low 64 bytes, with random upper address bits
    for (int i = 0; i < 300; i++) begin
      logic        wr, sx;
      logic [1:0]  w;
      logic [31:0] a, d;
      wr = 1'($urandom());
      sx = 1'($urandom());
      w  = 2'($urandom_range(0, 3));
      a  = $urandom() & 32'hFFFF_FC3F;
      d  = $urandom();
      do_req(wr, w, sx, a, d, rd, mis, lat);
      model(wr, w, sx, a, d, mrd, mmis);
      check($sformatf("rand%0d rdata", i), rd, mrd);
      check($sformatf("rand%0d misalign", i), {31'b0, mis}, {31'b0, mmis});
      check($sformatf("rand%0d latency", i), 32'(lat), mmis ? 32'd1 : 32'(LAT));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
